rf_write_scheduler: RTL and testbench

- Owns the single write port of the core register file and shares it between three sources: pipeline writeback (MW stage), R0 initialisation, and out-of-order load returns.
- Keeps a per-register pending-load scoreboard and produces the decode stall that guards RAW/WAW hazards against in-flight loads.
- Sits between the MW stage, the load unit and the register file's write/init inputs.

---
 rtl/rf_write_scheduler.sv | 128 ++++++++++++
 tb/tb_rf_write_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_scheduler.sv
// Single-write-port arbiter for the core register file (writeback > R0 init > load return)
// with a pending-load scoreboard that produces the decode stall.
module rf_write_scheduler #(
  parameter int DATA_W     = 8,
  parameter int PTR_W      = 4,
  parameter int REG_COUNT  = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_valid,
  input  logic [PTR_W-1:0]     wb_dst,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 init_valid,
  input  logic [DATA_W-1:0]    init_data,
  output logic                 init_ready,
  input  logic                 ld_issue,
  input  logic [PTR_W-1:0]     ld_issue_dst,
  input  logic                 ld_valid,
  input  logic [PTR_W-1:0]     ld_dst,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  input  logic [PTR_W-1:0]     D_src_0,
  input  logic [PTR_W-1:0]     D_src_1,
  input  logic [PTR_W-1:0]     D_src_2,
  input  logic [2:0]           D_src_used,
  input  logic [PTR_W-1:0]     D_dst,
  input  logic                 D_dst_used,
  output logic                 stall_D,
  output logic                 rf_we,
  output logic [PTR_W-1:0]     rf_dst,
  output logic [DATA_W-1:0]    rf_data,
  output logic [REG_COUNT-1:0] pending,
  output logic                 err_waw
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 1'b1;
  endfunction

  logic [PTR_W-1:0]  fifo_dst  [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve;
  logic              push, pop;
  logic              ld_src_p1;

  assign init_ready = !wb_valid;
  assign ld_ready   = (count != 2'd2);
  assign push       = ld_valid && ld_ready;
  assign pop        = !wb_valid && !init_valid && (count != 2'd0);
  assign starve     = (starve_cnt >= STARVE_LIM);

  // Stage p0 -> p1: arbitration winner registered onto the RF write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we     <= 1'b0;
      rf_dst    <= '0;
      rf_data   <= '0;
      ld_src_p1 <= 1'b0;
    end else begin
      rf_we     <= wb_valid || init_valid || pop;
      ld_src_p1 <= 1'b0;
      if (wb_valid) begin
        rf_dst  <= wb_dst;
        rf_data <= wb_data;
      end else if (init_valid) begin
        rf_dst  <= '0;
        rf_data <= init_data;
      end else if (pop) begin
        rf_dst    <= fifo_dst[rd_ptr];
        rf_data   <= fifo_data[rd_ptr];
        ld_src_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dst[wr_ptr]  <= ld_dst;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop || count == 2'd0) starve_cnt <= '0;
      else                      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Issue is applied after the load-commit clear so a same-edge set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      err_waw <= 1'b0;
    end else begin
      logic [REG_COUNT-1:0] nxt;
      nxt = pending;
      if (rf_we && ld_src_p1) nxt[rf_dst] = 1'b0;
      if (ld_issue)           nxt[ld_issue_dst] = 1'b1;
      pending <= nxt;
      if (wb_valid && pending[wb_dst]) err_waw <= 1'b1;
    end
  end

  always_comb begin
    stall_D = starve;
    if (D_src_used[0] && (pending[D_src_0] || (ld_issue && ld_issue_dst == D_src_0))) stall_D = 1'b1;
    if (D_src_used[1] && (pending[D_src_1] || (ld_issue && ld_issue_dst == D_src_1))) stall_D = 1'b1;
    if (D_src_used[2] && (pending[D_src_2] || (ld_issue && ld_issue_dst == D_src_2))) stall_D = 1'b1;
    if (D_dst_used    && (pending[D_dst]   || (ld_issue && ld_issue_dst == D_dst)))   stall_D = 1'b1;
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: arbitration, load FIFO, scoreboard, starvation, reset.
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic [7:0]  wb_data;
  logic        init_valid;
  logic [7:0]  init_data;
  logic        init_ready;
  logic        ld_issue;
  logic [3:0]  ld_issue_dst;
  logic        ld_valid;
  logic [3:0]  ld_dst;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [3:0]  D_src_0, D_src_1, D_src_2;
  logic [2:0]  D_src_used;
  logic [3:0]  D_dst;
  logic        D_dst_used;
  logic        stall_D;
  logic        rf_we;
  logic [3:0]  rf_dst;
  logic [7:0]  rf_data;
  logic [15:0] pending;
  logic        err_waw;

  int n_chk  = 0;
  int n_fail = 0;

  rf_write_scheduler #(.DATA_W(8), .PTR_W(4), .REG_COUNT(16), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .init_valid(init_valid), .init_data(init_data), .init_ready(init_ready),
    .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data), .ld_ready(ld_ready),
    .D_src_0(D_src_0), .D_src_1(D_src_1), .D_src_2(D_src_2), .D_src_used(D_src_used),
    .D_dst(D_dst), .D_dst_used(D_dst_used), .stall_D(stall_D),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data),
    .pending(pending), .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wb_valid = 0; wb_dst = 0; wb_data = 0;
    init_valid = 0; init_data = 0;
    ld_issue = 0; ld_issue_dst = 0;
    ld_valid = 0; ld_dst = 0; ld_data = 0;
    D_src_0 = 0; D_src_1 = 0; D_src_2 = 0; D_src_used = 0;
    D_dst = 0; D_dst_used = 0;
    step(); step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_dst", rf_dst, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err_waw", err_waw, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_init_ready", init_ready, 1);
    wb_valid = 1; settle();
    chk("rst_init_ready_wb", init_ready, 0);
    wb_valid = 0;
    reset_n = 1'b1;
    step();

    // Load issue to r5, decode reads r5, return commits two cycles after acceptance
    ld_issue = 1; ld_issue_dst = 5; D_src_0 = 5; D_src_used = 3'b001; settle();
    chk("issue_same_cycle_stall", stall_D, 1);
    step();
    ld_issue = 0; settle();
    chk("pending5_set", pending, 16'h0020);
    chk("pending5_stall", stall_D, 1);
    ld_valid = 1; ld_dst = 5; ld_data = 8'h3C; settle();
    chk("ld_ready_empty", ld_ready, 1);
    step();
    ld_valid = 0; settle();
    chk("no_bypass_we", rf_we, 0);
    step();
    chk("ld_commit_we", rf_we, 1);
    chk("ld_commit_dst", rf_dst, 5);
    chk("ld_commit_data", rf_data, 8'h3C);
    chk("pending5_still", pending, 16'h0020);
    step();
    chk("pending5_clear", pending, 0);
    chk("stall_drop", stall_D, 0);
    chk("idle_we", rf_we, 0);
    chk("idle_dst_hold", rf_dst, 5);

    // Writeback beats init; init goes the next cycle
    D_src_used = 0;
    wb_valid = 1; wb_dst = 2; wb_data = 8'h11;
    init_valid = 1; init_data = 8'h7F; settle();
    chk("init_ready_blocked", init_ready, 0);
    step();
    wb_valid = 0; settle();
    chk("wb_we", rf_we, 1);
    chk("wb_dst", rf_dst, 2);
    chk("wb_data", rf_data, 8'h11);
    chk("init_ready_free", init_ready, 1);
    step();
    init_valid = 0; settle();
    chk("init_we", rf_we, 1);
    chk("init_dst", rf_dst, 0);
    chk("init_data", rf_data, 8'h7F);
    step();
    chk("init_after_we", rf_we, 0);
    chk("no_waw_err", err_waw, 0);

    // Starvation: writeback held high, three load returns back to back
    wb_valid = 1; wb_dst = 1; wb_data = 8'hB1;
    ld_valid = 1; ld_dst = 8; ld_data = 8'hA1;
    step();
    ld_dst = 9; ld_data = 8'hA2;
    step();
    ld_dst = 10; ld_data = 8'hA3; settle();
    chk("fifo_full_ready", ld_ready, 0);
    step();
    step();
    chk("starve_cnt3_nostall", stall_D, 0);
    chk("wb_owns_port_dst", rf_dst, 1);
    step();
    chk("starve_stall", stall_D, 1);
    chk("starve_ld_ready", ld_ready, 0);
    chk("starve_wb_data", rf_data, 8'hB1);
    step();
    chk("starve_sat_stall", stall_D, 1);

    // Writeback drops: FIFO drains in order, held third return accepted
    wb_valid = 0;
    step();
    chk("drain1_we", rf_we, 1);
    chk("drain1_dst", rf_dst, 8);
    chk("drain1_data", rf_data, 8'hA1);
    chk("drain1_ready", ld_ready, 1);
    chk("drain1_stall", stall_D, 0);
    step();
    ld_valid = 0; settle();
    chk("drain2_dst", rf_dst, 9);
    chk("drain2_data", rf_data, 8'hA2);
    step();
    chk("drain3_dst", rf_dst, 10);
    chk("drain3_data", rf_data, 8'hA3);
    step();
    chk("drain_done_we", rf_we, 0);
    chk("drain_done_stall", stall_D, 0);

    // Issue of r7 on the same edge as a load commit of r7
    ld_issue = 1; ld_issue_dst = 7;
    step();
    ld_issue = 0; ld_valid = 1; ld_dst = 7; ld_data = 8'h55;
    step();
    ld_valid = 0;
    step();
    chk("r7_commit_dst", rf_dst, 7);
    chk("r7_commit_we", rf_we, 1);
    ld_issue = 1; ld_issue_dst = 7;
    step();
    ld_issue = 0; settle();
    chk("r7_set_wins", pending, 16'h0080);
    D_dst = 7; D_dst_used = 1; settle();
    chk("dst_waw_stall", stall_D, 1);
    D_dst_used = 0; settle();
    chk("dst_unused_nostall", stall_D, 0);

    // WAW error is sticky and writeback never clears pending
    ld_issue = 1; ld_issue_dst = 3;
    step();
    ld_issue = 0;
    wb_valid = 1; wb_dst = 3; wb_data = 8'h33;
    step();
    wb_valid = 0; settle();
    chk("err_waw_set", err_waw, 1);
    step();
    chk("err_waw_sticky", err_waw, 1);
    chk("wb_no_clear", pending, 16'h0088);

    // Reset asserted with the FIFO full
    wb_valid = 1; wb_dst = 1; wb_data = 8'hC1;
    ld_valid = 1; ld_dst = 4; ld_data = 8'h44;
    step();
    ld_data = 8'h45;
    step();
    ld_valid = 0; settle();
    chk("prereset_full", ld_ready, 0);
    reset_n = 1'b0; settle();
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_dst", rf_dst, 0);
    chk("mid_rst_data", rf_data, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_err", err_waw, 0);
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_stall", stall_D, 0);
    chk("mid_rst_init_ready", init_ready, 0);
    wb_valid = 0;
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_fifo_empty", rf_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
